fpu_sigs_exec_sched: RTL and testbench

//  Consumes the control-signal bundle produced by the FPU uop decoder, one uop per cycle with a tag.

---
 rtl/fpu_sigs_exec_sched_if.sv | 44 ++++
 rtl/fpu_sigs_exec_sched.sv | 124 ++++++++++++
 tb/tb_fpu_sigs_exec_sched.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_sigs_exec_sched_if.sv
// Issue-slot / writeback bundle between the FP issue slot and the FPU execution scheduler.
// The master side drives requests and flush; the slave side is the scheduler.
interface fpu_sigs_exec_sched_if #(
  parameter int TAG_W = 7
);
  logic             io_flush;
  logic             io_req_valid;
  logic             io_req_ready;
  logic [TAG_W-1:0] io_req_tag;
  logic             io_req_fma;
  logic             io_req_toint;
  logic             io_req_fastpipe;
  logic             io_req_fromint;
  logic             io_req_wflags;
  logic [1:0]       io_req_typeTagOut;
  logic             io_fma_fire;
  logic             io_fast_fire;
  logic             io_int_fire;
  logic             io_illegal;
  logic             io_fp_wb_valid;
  logic [TAG_W-1:0] io_fp_wb_tag;
  logic [1:0]       io_fp_wb_typeTag;
  logic             io_fp_wb_wflags;
  logic             io_int_wb_valid;
  logic [TAG_W-1:0] io_int_wb_tag;
  logic             io_int_wb_wflags;
  logic [3:0]       io_inflight;

  modport master (
    output io_flush, io_req_valid, io_req_tag, io_req_fma, io_req_toint,
           io_req_fastpipe, io_req_fromint, io_req_wflags, io_req_typeTagOut,
    input  io_req_ready, io_fma_fire, io_fast_fire, io_int_fire, io_illegal,
           io_fp_wb_valid, io_fp_wb_tag, io_fp_wb_typeTag, io_fp_wb_wflags,
           io_int_wb_valid, io_int_wb_tag, io_int_wb_wflags, io_inflight
  );

  modport slave (
    input  io_flush, io_req_valid, io_req_tag, io_req_fma, io_req_toint,
           io_req_fastpipe, io_req_fromint, io_req_wflags, io_req_typeTagOut,
    output io_req_ready, io_fma_fire, io_fast_fire, io_int_fire, io_illegal,
           io_fp_wb_valid, io_fp_wb_tag, io_fp_wb_typeTag, io_fp_wb_wflags,
           io_int_wb_valid, io_int_wb_tag, io_int_wb_wflags, io_inflight
  );
endinterface

// File: rtl/fpu_sigs_exec_sched.sv
// FPU execution scheduler: steers decoded uops to FMA / fast / toint pipes, tracks their fixed
// latencies as valid+payload shift chains and drives the shared FP and the integer writeback ports.
module fpu_sigs_exec_sched #(
  parameter int TAG_W    = 7,
  parameter int FAST_LAT = 2,
  parameter int FMA_LAT  = 4,
  parameter int INT_LAT  = 2
) (
  input  logic clock,
  input  logic reset,
  fpu_sigs_exec_sched_if.slave io
);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_FMA  = 2'd1;
  localparam logic [1:0] SEL_INT  = 2'd2;
  localparam logic [1:0] SEL_FAST = 2'd3;

  // An FMA sitting in this stage writes back exactly when a FAST uop issued now would.
  localparam int COLL_STAGE = FMA_LAT - FAST_LAT;
  localparam int FP_PW      = TAG_W + 3;
  localparam int INT_PW     = TAG_W + 1;

  logic [1:0]        sel;
  logic              ready;
  logic              fire;
  logic              fma_fire;
  logic              fast_fire;
  logic              int_fire;
  logic [FP_PW-1:0]  fp_req_p;
  logic [INT_PW-1:0] int_req_p;

  logic [FMA_LAT:1]  fma_v_q,  fma_v_d;
  logic [FAST_LAT:1] fast_v_q, fast_v_d;
  logic [INT_LAT:1]  int_v_q,  int_v_d;
  logic [FP_PW-1:0]  fma_p_q  [FMA_LAT:1];
  logic [FP_PW-1:0]  fast_p_q [FAST_LAT:1];
  logic [INT_PW-1:0] int_p_q  [INT_LAT:1];
  logic [3:0]        inflight_q, inflight_d;
  logic [FP_PW-1:0]  fp_wb_p;

  always_comb begin
    sel = SEL_NONE;
    if (io.io_req_fma)                              sel = SEL_FMA;
    else if (io.io_req_toint)                       sel = SEL_INT;
    else if (io.io_req_fastpipe || io.io_req_fromint) sel = SEL_FAST;
  end

  assign ready     = !reset && !io.io_flush && !(sel == SEL_FAST && fma_v_q[COLL_STAGE]);
  assign fire      = io.io_req_valid && ready;
  assign fma_fire  = fire && (sel == SEL_FMA);
  assign fast_fire = fire && (sel == SEL_FAST);
  assign int_fire  = fire && (sel == SEL_INT);
  assign fp_req_p  = {io.io_req_tag, io.io_req_typeTagOut, io.io_req_wflags};
  assign int_req_p = {io.io_req_tag, io.io_req_wflags};

  // Next-state valid chains; flush kills every stage at the edge ending the flush cycle.
  generate
    for (genvar gi = 1; gi <= FMA_LAT; gi++) begin : g_fma_v
      if (gi == 1) begin : g_head
        assign fma_v_d[gi] = fma_fire && !io.io_flush;
      end else begin : g_body
        assign fma_v_d[gi] = fma_v_q[gi-1] && !io.io_flush;
      end
    end
    for (genvar gi = 1; gi <= FAST_LAT; gi++) begin : g_fast_v
      if (gi == 1) begin : g_head
        assign fast_v_d[gi] = fast_fire && !io.io_flush;
      end else begin : g_body
        assign fast_v_d[gi] = fast_v_q[gi-1] && !io.io_flush;
      end
    end
    for (genvar gi = 1; gi <= INT_LAT; gi++) begin : g_int_v
      if (gi == 1) begin : g_head
        assign int_v_d[gi] = int_fire && !io.io_flush;
      end else begin : g_body
        assign int_v_d[gi] = int_v_q[gi-1] && !io.io_flush;
      end
    end
  endgenerate

  assign inflight_d = 4'($countones({fma_v_d, fast_v_d, int_v_d}));

  always_ff @(posedge clock) begin
    if (reset) begin
      fma_v_q    <= '0;
      fast_v_q   <= '0;
      int_v_q    <= '0;
      inflight_q <= '0;
      for (int k = 1; k <= FMA_LAT; k++)  fma_p_q[k]  <= '0;
      for (int k = 1; k <= FAST_LAT; k++) fast_p_q[k] <= '0;
      for (int k = 1; k <= INT_LAT; k++)  int_p_q[k]  <= '0;
    end else begin
      fma_v_q    <= fma_v_d;
      fast_v_q   <= fast_v_d;
      int_v_q    <= int_v_d;
      inflight_q <= inflight_d;
      // Payloads only move with a valid token so idle stages keep their last contents.
      if (fma_fire)  fma_p_q[1]  <= fp_req_p;
      if (fast_fire) fast_p_q[1] <= fp_req_p;
      if (int_fire)  int_p_q[1]  <= int_req_p;
      for (int k = 2; k <= FMA_LAT; k++)  if (fma_v_q[k-1])  fma_p_q[k]  <= fma_p_q[k-1];
      for (int k = 2; k <= FAST_LAT; k++) if (fast_v_q[k-1]) fast_p_q[k] <= fast_p_q[k-1];
      for (int k = 2; k <= INT_LAT; k++)  if (int_v_q[k-1])  int_p_q[k]  <= int_p_q[k-1];
    end
  end

  assign fp_wb_p = fma_v_q[FMA_LAT] ? fma_p_q[FMA_LAT] : fast_p_q[FAST_LAT];

  assign io.io_req_ready     = ready;
  assign io.io_fma_fire      = fma_fire;
  assign io.io_fast_fire     = fast_fire;
  assign io.io_int_fire      = int_fire;
  assign io.io_illegal       = fire && (sel == SEL_NONE);
  assign io.io_fp_wb_valid   = fma_v_q[FMA_LAT] || fast_v_q[FAST_LAT];
  assign io.io_fp_wb_tag     = fp_wb_p[FP_PW-1:3];
  assign io.io_fp_wb_typeTag = fp_wb_p[2:1];
  assign io.io_fp_wb_wflags  = fp_wb_p[0];
  assign io.io_int_wb_valid  = int_v_q[INT_LAT];
  assign io.io_int_wb_tag    = int_p_q[INT_LAT][INT_PW-1:1];
  assign io.io_int_wb_wflags = int_p_q[INT_LAT][0];
  assign io.io_inflight      = inflight_q;

endmodule

// File: tb/tb_fpu_sigs_exec_sched.sv
// Scoreboard bench for fpu_sigs_exec_sched: a uop-list reference model produces per-cycle
// expectations into a queue; a negedge monitor pops and compares them with the DUT outputs.
module tb_fpu_sigs_exec_sched;
  localparam int TAG_W    = 7;
  localparam int FAST_LAT = 2;
  localparam int FMA_LAT  = 4;
  localparam int INT_LAT  = 2;
  localparam int NCYC     = 3000;
  localparam int K_FMA = 0, K_INT = 1, K_FAST = 2, K_NONE = 3;

  typedef struct {
    bit rst; bit flush; bit v; bit [6:0] tag;
    bit fma; bit toint; bit fp; bit fi; bit wf; bit [1:0] tt;
  } item_t;

  typedef struct { int acc; int due; int kind; bit [6:0] tag; bit [1:0] tt; bit wf; } ent_t;

  typedef struct {
    int cyc; bit skip; bit ready; bit fmaf; bit fastf; bit intf; bit ill;
    bit fpv; bit [6:0] fptag; bit [1:0] fptt; bit fpwf;
    bit intv; bit [6:0] inttag; bit intwf; int infl;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  fpu_sigs_exec_sched_if #(.TAG_W(TAG_W)) bus ();

  fpu_sigs_exec_sched #(
    .TAG_W(TAG_W), .FAST_LAT(FAST_LAT), .FMA_LAT(FMA_LAT), .INT_LAT(INT_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(bus)
  );

  task automatic chk(input string nm, input int cyc, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  function automatic item_t mk(bit v, bit [6:0] tag, bit fma, bit toint, bit fp, bit fi,
                               bit wf, bit [1:0] tt, bit fl, bit rs);
    item_t r;
    r.v = v; r.tag = tag; r.fma = fma; r.toint = toint; r.fp = fp; r.fi = fi;
    r.wf = wf; r.tt = tt; r.flush = fl; r.rst = rs;
    return r;
  endfunction

  function automatic item_t rand_item();
    item_t r;
    r.rst   = ($urandom_range(999) < 5);
    r.flush = ($urandom_range(99) < 3);
    r.v     = ($urandom_range(99) < 70);
    r.tag   = 7'($urandom);
    r.fma   = ($urandom_range(99) < 30);
    r.toint = ($urandom_range(99) < 25);
    r.fp    = ($urandom_range(99) < 50);
    r.fi    = ($urandom_range(99) < 20);
    r.wf    = 1'($urandom);
    r.tt    = 2'($urandom);
    return r;
  endfunction

  // Monitor: one expectation per cycle, compared at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!e.skip) begin
          chk("ready",     e.cyc, int'(bus.io_req_ready),    int'(e.ready));
          chk("fma_fire",  e.cyc, int'(bus.io_fma_fire),     int'(e.fmaf));
          chk("fast_fire", e.cyc, int'(bus.io_fast_fire),    int'(e.fastf));
          chk("int_fire",  e.cyc, int'(bus.io_int_fire),     int'(e.intf));
          chk("illegal",   e.cyc, int'(bus.io_illegal),      int'(e.ill));
          chk("inflight",  e.cyc, int'(bus.io_inflight),     e.infl);
          chk("fp_wb_v",   e.cyc, int'(bus.io_fp_wb_valid),  int'(e.fpv));
          chk("int_wb_v",  e.cyc, int'(bus.io_int_wb_valid), int'(e.intv));
          if (e.fpv && bus.io_fp_wb_valid) begin
            chk("fp_wb_tag", e.cyc, int'(bus.io_fp_wb_tag),     int'(e.fptag));
            chk("fp_wb_tt",  e.cyc, int'(bus.io_fp_wb_typeTag), int'(e.fptt));
            chk("fp_wb_wf",  e.cyc, int'(bus.io_fp_wb_wflags),  int'(e.fpwf));
            $display("cyc=%0d fp wb tag=%0d tt=%0d wf=%0d", e.cyc, bus.io_fp_wb_tag,
                     bus.io_fp_wb_typeTag, bus.io_fp_wb_wflags);
          end
          if (e.intv && bus.io_int_wb_valid) begin
            chk("int_wb_tag", e.cyc, int'(bus.io_int_wb_tag),    int'(e.inttag));
            chk("int_wb_wf",  e.cyc, int'(bus.io_int_wb_wflags), int'(e.intwf));
            $display("cyc=%0d int wb tag=%0d wf=%0d", e.cyc, bus.io_int_wb_tag,
                     bus.io_int_wb_wflags);
          end
        end
      end
    end
  end

  // Driver + reference model: the model keeps a list of accepted uops with their due cycles.
  initial begin
    item_t dq[$];
    item_t it, u, held;
    ent_t  lst[$];
    ent_t  ne;
    exp_t  e;
    bit    held_v, prev_rst, blocked, fire;
    int    kind;

    held_v = 0; prev_rst = 0;
    held = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.io_flush = 0; bus.io_req_valid = 0; bus.io_req_tag = '0;
    bus.io_req_fma = 0; bus.io_req_toint = 0; bus.io_req_fastpipe = 0;
    bus.io_req_fromint = 0; bus.io_req_wflags = 0; bus.io_req_typeTagOut = '0;

    dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0));           // lone FMA
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 9, 0, 0, 0, 1, 0, 1, 0, 0));           // fromint via fast pipe
    for (int i = 0; i < 3; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 1, 1, 0, 0, 0, 1, 2, 0, 0));           // FMA then colliding FAST
    dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 2, 0, 0, 1, 0, 0, 3, 0, 0));
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 3, 0, 1, 0, 0, 1, 0, 0, 0));           // toint, FMA, FAST stream
    dq.push_back(mk(1, 4, 1, 1, 1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) dq.push_back(mk(1, 7'(10 + i), 0, 0, 1, 1, 1, 2'(i), 0, 0));
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 7, 0, 0, 0, 0, 1, 3, 0, 0));           // illegal
    for (int i = 0; i < 2; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) dq.push_back(mk(1, 7'(20 + i), 1, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));           // flush
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 30, 1, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(1, 31, 1, 0, 0, 0, 0, 0, 0, 0));
    dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));           // reset mid-stream
    for (int i = 0; i < 6; i++) dq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clock);
      #1;
      it = (dq.size() > 0) ? dq.pop_front() : rand_item();
      if (it.rst || prev_rst) begin
        u = mk(0, 0, 0, 0, 0, 0, 0, 0, it.flush, it.rst);
        held_v = 0;
      end else if (held_v) u = held;
      else u = it;
      if (!u.v) u = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      reset = it.rst;
      bus.io_flush = it.flush;
      bus.io_req_valid = u.v;           bus.io_req_tag = u.tag;
      bus.io_req_fma = u.fma;           bus.io_req_toint = u.toint;
      bus.io_req_fastpipe = u.fp;       bus.io_req_fromint = u.fi;
      bus.io_req_wflags = u.wf;         bus.io_req_typeTagOut = u.tt;

      e = '{default: 0};
      e.cyc = c; e.skip = it.rst;
      e.infl = lst.size();
      for (int i = lst.size() - 1; i >= 0; i--) begin
        if (lst[i].due == c) begin
          if (lst[i].kind == K_INT) begin
            e.intv = 1; e.inttag = lst[i].tag; e.intwf = lst[i].wf;
          end else begin
            e.fpv = 1; e.fptag = lst[i].tag; e.fptt = lst[i].tt; e.fpwf = lst[i].wf;
          end
          lst.delete(i);
        end
      end

      if (it.rst) begin
        lst.delete();
      end else begin
        if (it.flush) lst.delete();
        kind = u.fma ? K_FMA : u.toint ? K_INT : (u.fp || u.fi) ? K_FAST : K_NONE;
        blocked = 0;
        if (kind == K_FAST)
          foreach (lst[i]) if (lst[i].kind == K_FMA && lst[i].due == c + FAST_LAT) blocked = 1;
        e.ready = !it.flush && !blocked;
        fire    = u.v && e.ready;
        e.fmaf  = fire && kind == K_FMA;
        e.fastf = fire && kind == K_FAST;
        e.intf  = fire && kind == K_INT;
        e.ill   = fire && kind == K_NONE;
        if (fire && kind != K_NONE) begin
          ne.acc = c; ne.kind = kind; ne.tag = u.tag; ne.tt = u.tt; ne.wf = u.wf;
          ne.due = c + ((kind == K_FMA) ? FMA_LAT : (kind == K_INT) ? INT_LAT : FAST_LAT);
          lst.push_back(ne);
        end
        held_v = u.v && !fire;
        held = u;
      end
      prev_rst = it.rst;
      exp_q.push_back(e);
    end

    @(negedge clock);
    #1;
    chk("drain", NCYC, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
